// File: rtl/generador_pixel.sv
// Pixel/colour generator that sits behind the VGA sync generator.
// Draws a 1-pixel screen border and a square box that bounces around the
// visible area. The box position advances once per frame, on the falling
// edge of vsync. rgb, hsync and vsync all leave through the same two
// register stages, so they stay aligned with each other.
module generador_pixel #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BOX_SIZE     = 32,
    parameter int          STEP         = 2,
    parameter int          X0           = 304,
    parameter int          Y0           = 224,
    parameter logic [11:0] BG_COLOR     = 12'h00F,
    parameter logic [11:0] BOX_COLOR    = 12'hFF0,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_mov,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        vidon_in,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    typedef enum logic { RIGHT, LEFT } dir_x_t;
    typedef enum logic { DOWN, UP } dir_y_t;

    // Everything is compared at 11 bits so that box + size never wraps.
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] X0_W   = 11'(X0);
    localparam logic [10:0] Y0_W   = 11'(Y0);

    logic [10:0] px_w, py_w;
    logic        tick_now;

    logic        vidon_s1_d, vidon_s1_q;
    logic        hs_s1_d, hs_s1_q, vs_s1_d, vs_s1_q;
    logic        in_box_d, in_box_q, in_border_d, in_border_q;
    logic        hs_s2_d, hs_s2_q, vs_s2_d, vs_s2_q;
    logic [11:0] rgb_d, rgb_q;
    logic        vsync_d, vsync_q;
    logic        frame_tick_d, frame_tick_q;
    logic [10:0] box_x_d, box_x_q, box_y_d, box_y_q;
    dir_x_t      dir_x_d, dir_x_q;
    dir_y_t      dir_y_d, dir_y_q;

    assign px_w = {1'b0, px};
    assign py_w = {1'b0, py};

    // Stage 1: sample syncs and vidon, and classify the current pixel.
    always_comb begin
        vidon_s1_d  = vidon_in;
        hs_s1_d     = hsync_in;
        vs_s1_d     = vsync_in;
        in_box_d    = (px_w >= box_x_q) && (px_w < box_x_q + SIZE_W) &&
                      (py_w >= box_y_q) && (py_w < box_y_q + SIZE_W);
        in_border_d = (px_w == 11'd0) || (px_w == H_LAST) ||
                      (py_w == 11'd0) || (py_w == V_LAST);
    end

    // Stage 2: pick the colour (blanking first, then box over border).
    always_comb begin
        hs_s2_d = hs_s1_q;
        vs_s2_d = vs_s1_q;
        rgb_d   = BG_COLOR;
        if (!vidon_s1_q) begin
            rgb_d = 12'h000;
        end else if (in_box_q) begin
            rgb_d = BOX_COLOR;
        end else if (in_border_q) begin
            rgb_d = BORDER_COLOR;
        end
    end

    // Falling edge of vsync marks the start of vertical blanking.
    always_comb begin
        vsync_d      = vsync_in;
        tick_now     = vsync_q && !vsync_in;
        frame_tick_d = tick_now;
    end

    // Horizontal direction FSM: clamp and reverse in the same update.
    always_comb begin
        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        if (tick_now && en_mov) begin
            case (dir_x_q)
                RIGHT: begin
                    if (box_x_q + STEP_W > X_MAX) begin
                        box_x_d = X_MAX;
                        dir_x_d = LEFT;
                    end else begin
                        box_x_d = box_x_q + STEP_W;
                    end
                end
                LEFT: begin
                    if (box_x_q < STEP_W) begin
                        box_x_d = 11'd0;
                        dir_x_d = RIGHT;
                    end else begin
                        box_x_d = box_x_q - STEP_W;
                    end
                end
                default: begin
                    dir_x_d = RIGHT;
                end
            endcase
        end
    end

    // Vertical direction FSM, mirror of the horizontal one.
    always_comb begin
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;
        if (tick_now && en_mov) begin
            case (dir_y_q)
                DOWN: begin
                    if (box_y_q + STEP_W > Y_MAX) begin
                        box_y_d = Y_MAX;
                        dir_y_d = UP;
                    end else begin
                        box_y_d = box_y_q + STEP_W;
                    end
                end
                UP: begin
                    if (box_y_q < STEP_W) begin
                        box_y_d = 11'd0;
                        dir_y_d = DOWN;
                    end else begin
                        box_y_d = box_y_q - STEP_W;
                    end
                end
                default: begin
                    dir_y_d = DOWN;
                end
            endcase
        end
    end

    // Pixel pipeline registers; sync stages reset to the idle-high level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vidon_s1_q  <= 1'b0;
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            in_box_q    <= 1'b0;
            in_border_q <= 1'b0;
            hs_s2_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
            rgb_q       <= 12'h000;
        end else begin
            vidon_s1_q  <= vidon_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            in_box_q    <= in_box_d;
            in_border_q <= in_border_d;
            hs_s2_q     <= hs_s2_d;
            vs_s2_q     <= vs_s2_d;
            rgb_q       <= rgb_d;
        end
    end

    // Frame edge detector and box position/direction state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            box_x_q      <= X0_W;
            box_y_q      <= Y0_W;
            dir_x_q      <= RIGHT;
            dir_y_q      <= DOWN;
        end else begin
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
        end
    end

    assign hsync      = hs_s2_q;
    assign vsync      = vs_s2_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_generador_pixel.sv
// Testbench for generador_pixel. A behavioural model tracks the box as a
// plain (x, y, dx, dy) position/velocity pair and predicts every output on
// every clock; fixed vectors and hand sequences pin down known pixels.
module tb_generador_pixel;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BOX      = 32;
    localparam int STEP     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_mov;
    logic        hsync_in;
    logic        vsync_in;
    logic        vidon_in;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: box position as integers, velocity sign per axis.
    int mx, my, mdx, mdy;
    bit m_vprev;
    typedef struct { logic [11:0] rgb; logic hs; logic vs; } pipe_t;
    pipe_t pipe_q[$];
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_tick;

    typedef struct { logic vid; int x; int y; logic [11:0] exp; string name; } vec_t;
    vec_t vecs[10];

    generador_pixel dut (
        .clk        (clk),
        .rst        (rst),
        .en_mov     (en_mov),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .vidon_in   (vidon_in),
        .px         (px),
        .py         (py),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] model_color(logic vid, int x, int y);
        if (!vid) return 12'h000;
        if (x >= mx && x < mx + BOX && y >= my && y < my + BOX) return 12'hFF0;
        if (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) return 12'hFFF;
        return 12'h00F;
    endfunction

    task automatic model_reset();
        pipe_t s;
        mx = 304; my = 224; mdx = 1; mdy = 1; m_vprev = 1'b1;
        pipe_q.delete();
        s.rgb = 12'h000; s.hs = 1'b1; s.vs = 1'b1;
        pipe_q.push_back(s);
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_tick = 1'b0;
    endtask

    // Bounce: move by velocity, clamp into range and flip velocity when it overshoots.
    task automatic model_move();
        int nx, ny;
        nx = mx + mdx * STEP;
        ny = my + mdy * STEP;
        if (nx > H_ACTIVE - BOX) begin mx = H_ACTIVE - BOX; mdx = -1; end
        else if (nx < 0) begin mx = 0; mdx = 1; end
        else mx = nx;
        if (ny > V_ACTIVE - BOX) begin my = V_ACTIVE - BOX; mdy = -1; end
        else if (ny < 0) begin my = 0; mdy = 1; end
        else my = ny;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        check("rgb", rgb, e_rgb);
        check("hsync", 12'(hsync), 12'(e_hs));
        check("vsync", 12'(vsync), 12'(e_vs));
        check("frame_tick", 12'(frame_tick), 12'(e_tick));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after.
    task automatic applyStimulus(input logic vid, input int x, input int y,
                                 input logic hs, input logic vs, input logic en);
        pipe_t s;
        vidon_in = vid; px = x[9:0]; py = y[9:0];
        hsync_in = hs; vsync_in = vs; en_mov = en;
        @(posedge clk);
        s.rgb = model_color(vid, x, y); s.hs = hs; s.vs = vs;
        pipe_q.push_back(s);
        s = pipe_q.pop_front();
        e_rgb = s.rgb; e_hs = s.hs; e_vs = s.vs;
        e_tick = m_vprev && !vs;
        m_vprev = vs;
        if (e_tick && en) model_move();
        #1;
        checkOutput();
    endtask

    // Show one pixel and read its colour two clocks later.
    task automatic probe(input string name, input int x, input int y, input logic [11:0] exp);
        applyStimulus(1'b1, x, y, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        check(name, rgb, exp);
    endtask

    // One vertical blanking: vsync low for 'low' clocks, counting frame_tick pulses.
    task automatic doTick(input logic en, input int low, output int cnt);
        cnt = 0;
        applyStimulus(1'b0, 700, 500, 1'b1, 1'b1, en);
        for (int i = 0; i < low; i++) begin
            applyStimulus(1'b0, 700, 500, 1'b1, 1'b0, en);
            if (frame_tick === 1'b1) cnt++;
        end
        applyStimulus(1'b0, 700, 500, 1'b1, 1'b1, en);
        if (frame_tick === 1'b1) cnt++;
    endtask

    // Asynchronous reset in the middle of a clock period.
    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_rgb", rgb, 12'h000);
        check("rst_hsync", 12'(hsync), 12'h001);
        check("rst_vsync", 12'(vsync), 12'h001);
        check("rst_frame_tick", 12'(frame_tick), 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cnt, total, x, y, low;
        logic en;

        vecs[0] = '{1'b1, 310, 230, 12'hFF0, "vec_box"};
        vecs[1] = '{1'b1, 100, 230, 12'h00F, "vec_bg"};
        vecs[2] = '{1'b1,   0, 230, 12'hFFF, "vec_left_border"};
        vecs[3] = '{1'b0, 310, 230, 12'h000, "vec_blank"};
        vecs[4] = '{1'b1, 639, 100, 12'hFFF, "vec_right_border"};
        vecs[5] = '{1'b1, 200, 479, 12'hFFF, "vec_bottom_border"};
        vecs[6] = '{1'b1, 304, 224, 12'hFF0, "vec_box_corner"};
        vecs[7] = '{1'b1, 336, 224, 12'h00F, "vec_box_right_excl"};
        vecs[8] = '{1'b1, 335, 255, 12'hFF0, "vec_box_far_corner"};
        vecs[9] = '{1'b1, 335, 256, 12'h00F, "vec_box_bottom_excl"};

        rst = 1'b0; en_mov = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        vidon_in = 1'b0; px = '0; py = '0;
        #12;
        model_reset();
        checkOutput();
        @(negedge clk);
        rst = 1'b1;

        // Fixed pixel vectors with the box at its reset position.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].vid, vecs[i].x, vecs[i].y, 1'b1, 1'b1, 1'b1);
            applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
            check(vecs[i].name, rgb, vecs[i].exp);
        end

        // Reset mid-line while the box colour is on the output.
        applyStimulus(1'b1, 310, 230, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 311, 230, 1'b0, 1'b1, 1'b1);
        check("pre_reset_rgb", rgb, 12'hFF0);
        doReset();
        probe("post_reset_box", 304, 224, 12'hFF0);
        probe("post_reset_left", 303, 224, 12'h00F);

        // First frame: vsync held low for a long time gives a single tick.
        doTick(1'b1, 20, cnt);
        check("tick_count_long_low", 12'(cnt), 12'd1);
        probe("move1_box", 306, 226, 12'hFF0);
        probe("move1_left", 305, 226, 12'h00F);
        probe("move1_top", 306, 225, 12'h00F);

        // Run to the right edge: after 152 ticks x=608, y=370.
        for (int i = 1; i < 152; i++) doTick(1'b1, 2, cnt);
        probe("edge_x608", 608, 370, 12'hFF0);
        probe("edge_x607", 607, 370, 12'h00F);
        probe("edge_box_over_border", 639, 370, 12'hFF0);
        probe("edge_y_last", 608, 401, 12'hFF0);
        doTick(1'b1, 2, cnt);
        probe("clamp_x608", 608, 368, 12'hFF0);
        probe("clamp_y367", 608, 367, 12'h00F);
        doTick(1'b1, 2, cnt);
        probe("back_x606", 606, 366, 12'hFF0);
        probe("back_x638", 638, 366, 12'h00F);
        probe("back_x637", 637, 366, 12'hFF0);

        // Movement disabled: ticks still happen, the box stays put.
        total = 0;
        for (int i = 0; i < 3; i++) begin
            doTick(1'b0, 3, cnt);
            total += cnt;
        end
        check("frozen_tick_count", 12'(total), 12'd3);
        probe("frozen_box", 606, 366, 12'hFF0);
        probe("frozen_left", 605, 366, 12'h00F);
        probe("frozen_top", 606, 365, 12'h00F);
        doTick(1'b1, 2, cnt);
        probe("resume_box", 604, 364, 12'hFF0);
        probe("resume_right", 636, 364, 12'h00F);
        probe("resume_bottom", 604, 396, 12'h00F);

        // Random frames against the model, probing around the box edges.
        for (int f = 0; f < 700; f++) begin
            en = ($urandom_range(0, 9) != 0);
            if (f == 600) doReset();
            for (int c = 0; c < 6; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = mx + $urandom_range(0, BOX + 3) - 2;
                    y = my + $urandom_range(0, BOX + 3) - 2;
                end else begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                end
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                applyStimulus(($urandom_range(0, 7) != 0), x, y,
                              1'($urandom_range(0, 1)), 1'b1, en);
            end
            low = $urandom_range(1, 3);
            for (int c = 0; c < low; c++) begin
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 639),
                              $urandom_range(0, 479), 1'($urandom_range(0, 1)), 1'b0, en);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/generador_pixel.md
Name: generador_pixel

Overview:
Pixel/colour generator downstream of the VGA sync generator (sincronizador). Consumes px, py, vidon, hsync and vsync each pixel clock and produces registered 12-bit RGB (4:4:4). The hsync and vsync outputs are delayed so they stay aligned with the RGB output. The image is a screen border plus a square box that bounces around the 640x480 active area, with position updated once per frame during vertical blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, box side length in pixels
STEP, 2, box displacement per frame per axis (pixels)
X0, 304, box x position after reset
Y0, 224, box y position after reset
BG_COLOR, 12'h00F, background colour
BOX_COLOR, 12'hFF0, box colour
BORDER_COLOR, 12'hFFF, 1-pixel screen-edge colour

Ports:
clk  input  1  pixel clock, same clock as sincronizador
rst  input  1  asynchronous, active-low reset
en_mov  input  1  1 = box moves each frame; 0 = box position and direction frozen
hsync_in  input  1  hsync from sincronizador, active-low
vsync_in  input  1  vsync from sincronizador, active-low
vidon_in  input  1  active-video flag from sincronizador
px  input  10  current pixel column
py  input  10  current pixel row
hsync  output  1  hsync_in delayed 2 cycles
vsync  output  1  vsync_in delayed 2 cycles
rgb  output  12  pixel colour {R[3:0],G[3:0],B[3:0]}, registered
frame_tick  output  1  1-cycle pulse on each detected vsync_in falling edge

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-frame) forces:
  - rgb=0, hsync=1, vsync=1, frame_tick=0.
  - All pipeline registers cleared; sync pipeline stages set to 1.
  - box_x=X0, box_y=Y0, dir_x=right, dir_y=down, vsync_q=1.
- Pipeline, fixed latency of 2 clk for rgb, hsync and vsync relative to inputs.
  - Stage 1 registers vidon, hsync_in, vsync_in and computes:
    - in_box = (px>=box_x)&&(px<box_x+BOX_SIZE)&&(py>=box_y)&&(py<box_y+BOX_SIZE)
    - in_border = (px==0)||(px==H_ACTIVE-1)||(py==0)||(py==V_ACTIVE-1)
  - Stage 2 registers rgb using this priority:
    - vidon delayed = 0 -> 12'h000
    - in_box -> BOX_COLOR
    - in_border -> BORDER_COLOR
    - otherwise -> BG_COLOR
  - All comparisons use 11-bit widened arithmetic, so box_x+BOX_SIZE cannot overflow.
- Frame tick:
  - vsync_q holds the previous vsync_in.
  - frame_tick=1 for exactly one cycle, in the cycle after vsync_q=1 and vsync_in=0 are sampled. It is a registered output.
  - A vsync held low produces no further ticks.
- Box motion: a two-state direction FSM per axis (RIGHT/LEFT, DOWN/UP), evaluated only on the cycle where the edge is detected, and only if en_mov=1.
  - RIGHT: if box_x+STEP > H_ACTIVE-BOX_SIZE, then box_x=H_ACTIVE-BOX_SIZE and dir->LEFT; else box_x+=STEP.
  - LEFT: if box_x < STEP, then box_x=0 and dir->RIGHT; else box_x-=STEP.
  - The Y axis behaves identically with V_ACTIVE, DOWN and UP.
  - Clamp and reversal happen in the same update.
  - en_mov=0 at the tick: position and direction hold. frame_tick still pulses.
- Updates happen only in vertical blanking, since the vsync edge lies outside the active region. No tearing within a frame.
- Pixels with px>=H_ACTIVE or py>=V_ACTIVE are not specially handled; vidon gating blanks them.

Test Plan:
1. Assert rst=0 mid-line with rgb nonzero -> same cycle: rgb=0, hsync=1, vsync=1, frame_tick=0; after release, first frame box at (304,224).
2. vidon_in=1, px=310, py=230 with box at (304,224) -> 2 clk later rgb=12'hFF0. Same stimulus with px=100 -> 12'h00F. px=0 -> 12'hFFF. vidon_in=0 -> 12'h000.
3. Toggle hsync_in/vsync_in in an arbitrary pattern -> hsync/vsync reproduce it exactly 2 clk later; rgb is aligned with the corresponding sync sample.
4. Drive vsync_in 1->0, held low for 2 lines -> frame_tick high exactly 1 cycle. With en_mov=1, box moves to (306,226).
5. Preload box_x=607 moving right (run frames) -> next tick box_x=608, dir LEFT; following tick box_x=606. Symmetric check at box_x=1 moving left -> 0, then 2.
6. en_mov=0 across 3 ticks -> box_x, box_y and directions unchanged; frame_tick still pulses 3 times. Re-enable -> motion resumes in the held direction.
